rnn_seq_ctrl: RTL and testbench
===============================

# rnn_seq_ctrl

Sequencer for the two-layer RNN datapath. It runs a single shared signed multiply-accumulate unit over the input vector, the layer-0 weight matrix (IN0×H) and the layer-1 weight matrix (H×H), and produces hidden vectors h0 and h1. It sits inside `rnn` between the register-mapped input/weight storage (`input_char`, `rnn_0`, `rnn_1`) and the host slave port. The host writes `start`, polls `busy`/`done`, then reads h1 by index.

## Interface
Parameters:
- `W`, 16: data width; signed two's complement.
- `IN0`, 2: input vector length, which is also the layer-0 row count.
- `H`, 4: hidden size, which is the column count of both layers and the row count of layer 1.
- `FRAC`, 0: fractional bits; the accumulator is arithmetically shifted right by FRAC before saturation.

Ports (`AW` = $clog2(max(IN0,H))):
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: synchronous, active-low reset.
- Control:
  - `start` in 1: starts a run; sampled only in IDLE.
  - `busy` out 1: high from the cycle after start is accepted until DONE, inclusive.
  - `done` out 1: one-cycle pulse in DONE.
- Weight read port:
  - `w_sel` out 1: 0 selects the layer-0 matrix, 1 selects layer 1.
  - `w_row`, `w_col` out AW: weight address.
  - `w_data` in W: weight read data, valid one cycle after the address.
- Input vector read port:
  - `x_idx` out AW: input vector address.
  - `x_data` in W: input read data, valid one cycle after the address.
- Result read port:
  - `h_idx` in AW: h1 index.
  - `h_data` out W: combinational h1[h_idx].
  - `h_valid` out 1: high once a run completes; cleared on start or reset.

## Operation
- Computation:
  - h0[c] = sat(Σ_{r<IN0} x[r]·W0[r][c] >>> FRAC).
  - h1[c] = sat(Σ_{r<H} h0[r]·W1[r][c] >>> FRAC).
  - Products are 2W bits. The accumulator is 2W+$clog2(H)+1 bits, so it never wraps.
  - `sat` clamps to [−2^(W−1), 2^(W−1)−1]. There is no activation function.
- State machine states: IDLE, ADDR, MAC, STORE, DONE. Counters: `layer` (0/1), `col`, `row`.
- IDLE:
  - On `start`: clear acc, row, col and layer; clear h_valid; go to ADDR.
  - Without `start`: stay.
- ADDR:
  - Drive w_sel=layer, w_row=row, w_col=col, x_idx=row.
  - For layer 1, latch operand h0[row] into the operand register.
  - Go to MAC.
- MAC:
  - acc += operand·w_data. The operand is x_data in layer 0 and the latched h0 in layer 1.
  - If row is the last row of the current layer: go to STORE.
  - Otherwise: row++ and go to ADDR.
- STORE:
  - Write sat(acc>>>FRAC) into h0[col] (layer 0) or h1[col] (layer 1). Clear acc and row.
  - If col≠H−1: col++, go to ADDR.
  - Else if layer=0: layer=1, col=0, go to ADDR.
  - Else: go to DONE.
- DONE:
  - Pulse `done`, set h_valid, go to IDLE.
- `start` while busy is ignored and not queued. `start` held high in IDLE after DONE starts a new run.
- Address outputs hold their last value outside ADDR. Storage contents must not change while busy; the host enforces this using `busy`.

## Timing
- Cycle budget:
  - A column of K terms takes 2K+1 cycles.
  - Layer 0 takes H·(2·IN0+1) = 20 cycles; layer 1 takes H·(2H+1) = 36 cycles.
  - `done` is high in the 57th cycle after the edge that sampled start, for default parameters.
- Read latency is exactly 1 cycle. The address driven in ADDR is consumed in the MAC cycle that follows.
- Reset values: state IDLE; busy=0, done=0, h_valid=0; w_sel, w_row, w_col, x_idx=0; acc, h0, h1 all 0, so h_data=0.
- Reset asserted mid-run returns to IDLE on the next edge, discards partial results, and produces no `done`.
- h0/h1 register writes occur on the STORE edge. `h_data` reflects a new value in the cycle after STORE.

## Structure
- `rnn_pkg` holds:
  - `state_t` enum.
  - W, IN0, H and FRAC default localparams.
  - `sat_w()` saturation function.
- Sub-module `rnn_mac` holds:
  - Signed W×W multiply.
  - The accumulator, with clear/enable inputs.
  - Shift-and-saturate output.
- The controller holds the FSM, the counters and the h0/h1 register arrays.

## Test plan
- Reference run:
  - Stimulus: x=[2,−3]. W0 rows {2,−10,−10,3}, {6,9,12,1}. W1 rows {−2,−3,−5,−3}, {−1,10,−2,−6}, {4,11,3,−12}, {−11,−4,3,−1}. Pulse start.
  - Response: h0=[−14,−47,−56,3] and h1=[−182,−1056,5,993]. `done` in the 57th cycle after the start edge; `busy` high for exactly 57 cycles; h_valid=1 afterward.
- Saturation:
  - Stimulus: x=[32767,32767], all weights 32767 → h1 all 32767.
  - Stimulus: x=[−32768,−32768], all weights 32767 → h0 all −32768, h1 all −32768.
- Start while busy: pulse start again at cycle 10 of a run → a single `done` at cycle 57, results unchanged.
- Reset mid-run: assert rst_n=0 at cycle 30 for 1 cycle → busy=0, h_valid=0, h_data=0 for every index, no `done`. A subsequent start gives the correct results.
- Address sequencing:
  - Bench memory model with 1-cycle latency; check the sequence of (w_sel, w_row, w_col) in ADDR cycles.
  - Required order: layer-0 pairs (0,0,0),(0,1,0),(0,0,1),…, then layer-1 pairs (1,0,0)…(1,3,3), with row varying fastest.
- Back-to-back runs: hold start high across DONE with new x=[1,0] and W0=identity-like → the second run starts immediately and h0 equals row 0 of W0.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared types, default sizes and arithmetic helpers for the RNN sequencer.
package rnn_pkg;

    localparam int RNN_W    = 16;
    localparam int RNN_IN0  = 2;
    localparam int RNN_H    = 4;
    localparam int RNN_FRAC = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_MAC,
        ST_STORE,
        ST_DONE
    } state_t;

    // Index width for the larger of the two vector dimensions, never below 1 bit.
    function automatic int rnn_aw(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/rnn_seq_ctrl_if.sv
// Host control, storage read ports and h1 result port of the RNN sequencer.
interface rnn_seq_ctrl_if #(
    parameter int W  = rnn_pkg::RNN_W,
    parameter int AW = rnn_pkg::rnn_aw(rnn_pkg::RNN_IN0, rnn_pkg::RNN_H)
);

    // Control
    logic          start;
    logic          busy;
    logic          done;
    // Weight read port
    logic          w_sel;
    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;
    logic [W-1:0]  w_data;
    // Input vector read port
    logic [AW-1:0] x_idx;
    logic [W-1:0]  x_data;
    // Result read port
    logic [AW-1:0] h_idx;
    logic [W-1:0]  h_data;
    logic          h_valid;

    // Sequencer side
    modport slave (
        input  start, w_data, x_data, h_idx,
        output busy, done, w_sel, w_row, w_col, x_idx, h_data, h_valid
    );

    // Host and storage side
    modport master (
        output start, w_data, x_data, h_idx,
        input  busy, done, w_sel, w_row, w_col, x_idx, h_data, h_valid
    );

endinterface

// File: rtl/rnn_mac.sv
// Signed multiply-accumulate with clear/enable and a shift-and-saturate output.
module rnn_mac
    import rnn_pkg::*;
#(
    parameter int W    = RNN_W,
    parameter int H    = RNN_H,
    parameter int FRAC = RNN_FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sat_out
);

    // Wide enough for H full-scale products plus sign, so the sum never wraps.
    localparam int ACC_W = 2 * W + $clog2(H) + 1;

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] shifted;

    assign prod = a * b;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        // NOTE: default assignment first, so no branch leaves acc_d unassigned and no latch is inferred.
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: flops are written with <= so every register samples pre-edge values.
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Scale down by the fractional bits, then clamp into a W-bit word.
    always_comb begin
        shifted = acc_q >>> FRAC;
        sat_out = W'(sat_w(64'(shifted), W));
    end

endmodule

// File: rtl/rnn_seq_ctrl.sv
// Two-layer RNN sequencer: walks the shared MAC over x*W0 into h0, then h0*W1 into h1.
module rnn_seq_ctrl
    import rnn_pkg::*;
#(
    parameter int W    = RNN_W,
    parameter int IN0  = RNN_IN0,
    parameter int H    = RNN_H,
    parameter int FRAC = RNN_FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    rnn_seq_ctrl_if.slave bus
);

    localparam int AW = rnn_aw(IN0, H);
    localparam logic [AW-1:0] LAST_ROW0 = AW'(IN0 - 1);
    localparam logic [AW-1:0] LAST_ROW1 = AW'(H - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(H - 1);

    state_t        state_d, state_q;
    logic          layer_d, layer_q;
    logic [AW-1:0] row_d, row_q;
    logic [AW-1:0] col_d, col_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic          h_valid_d, h_valid_q;
    logic          w_sel_d, w_sel_q;
    logic [AW-1:0] w_row_d, w_row_q;
    logic [AW-1:0] w_col_d, w_col_q;
    logic [AW-1:0] x_idx_d, x_idx_q;
    logic [W-1:0]  op_d, op_q;
    logic [W-1:0]  h0_d [H];
    logic [W-1:0]  h0_q [H];
    logic [W-1:0]  h1_d [H];
    logic [W-1:0]  h1_q [H];

    logic                mac_clr;
    logic                mac_en;
    logic signed [W-1:0] operand;
    logic signed [W-1:0] mac_sat;
    logic [AW-1:0]       last_row;

    // Layer 0 multiplies by the input vector straight from storage; layer 1 by the latched h0 entry.
    assign operand  = layer_q ? op_q : bus.x_data;
    assign last_row = layer_q ? LAST_ROW1 : LAST_ROW0;

    rnn_mac #(
        .W    (W),
        .H    (H),
        .FRAC (FRAC)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (operand),
        .b       (bus.w_data),
        .sat_out (mac_sat)
    );

    // Sequencer next-state: state, counters, registered outputs and result arrays.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        col_d     = col_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        h_valid_d = h_valid_q;
        w_sel_d   = w_sel_q;
        w_row_d   = w_row_q;
        w_col_d   = w_col_q;
        x_idx_d   = x_idx_q;
        op_d      = op_q;
        h0_d      = h0_q;
        h1_d      = h1_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mac_clr   = 1'b1;
                    layer_d   = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    h_valid_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (layer_q) begin
                    op_d = h0_q[row_q];
                end
                state_d = ST_MAC;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (row_q == last_row) begin
                    state_d = ST_STORE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_STORE: begin
                mac_clr = 1'b1;
                row_d   = '0;
                if (!layer_q) begin
                    h0_d[col_q] = mac_sat;
                end else begin
                    h1_d[col_q] = mac_sat;
                end
                if (col_q != LAST_COL) begin
                    col_d   = col_q + 1'b1;
                    state_d = ST_ADDR;
                end else if (!layer_q) begin
                    layer_d = 1'b1;
                    col_d   = '0;
                    state_d = ST_ADDR;
                end else begin
                    done_d    = 1'b1;
                    h_valid_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Addresses are loaded on entry to ADDR, so storage sees them during ADDR and answers in MAC.
        if (state_d == ST_ADDR) begin
            w_sel_d = layer_d;
            w_row_d = row_d;
            w_col_d = col_d;
            x_idx_d = row_d;
        end
    end

    // All sequencer state, including the h0/h1 result arrays.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            layer_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            h_valid_q <= 1'b0;
            w_sel_q   <= 1'b0;
            w_row_q   <= '0;
            w_col_q   <= '0;
            x_idx_q   <= '0;
            op_q      <= '0;
            // NOTE: the result arrays are small flop banks that must read back as zero after reset, so they are reset like any other register.
            h0_q      <= '{default: '0};
            h1_q      <= '{default: '0};
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            row_q     <= row_d;
            col_q     <= col_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            h_valid_q <= h_valid_d;
            w_sel_q   <= w_sel_d;
            w_row_q   <= w_row_d;
            w_col_q   <= w_col_d;
            x_idx_q   <= x_idx_d;
            op_q      <= op_d;
            h0_q      <= h0_d;
            h1_q      <= h1_d;
        end
    end

    // Combinational h1 read; indices beyond the hidden size read as zero.
    always_comb begin
        bus.h_data = '0;
        if (int'(bus.h_idx) < H) begin
            bus.h_data = h1_q[bus.h_idx];
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.h_valid = h_valid_q;
    assign bus.w_sel   = w_sel_q;
    assign bus.w_row   = w_row_q;
    assign bus.w_col   = w_col_q;
    assign bus.x_idx   = x_idx_q;

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// Self-checking bench for rnn_seq_ctrl: storage model with 1-cycle read latency and an arithmetic reference model.
module tb_rnn_seq_ctrl;

    localparam int W         = 16;
    localparam int IN0       = 2;
    localparam int H         = 4;
    localparam int AW        = 2;
    localparam int FRAC      = 0;
    localparam int EXP_CYC   = 57;
    localparam int RUN_LIMIT = 62;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rnn_seq_ctrl_if #(.W(W), .AW(AW)) bus ();

    rnn_seq_ctrl #(
        .W    (W),
        .IN0  (IN0),
        .H    (H),
        .FRAC (FRAC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic signed [W-1:0] x_mem  [IN0];
    logic signed [W-1:0] w0_mem [IN0][H];
    logic signed [W-1:0] w1_mem [H][H];
    longint              exp_h0 [H];
    longint              exp_h1 [H];
    int                  addr_log [$];
    int                  n_tests = 0;
    int                  n_fail  = 0;

    // Storage model: registered read, data valid the cycle after the address.
    always @(posedge clk) begin : mem_model
        int r;
        int c;
        int xi;
        r  = int'(bus.w_row);
        c  = int'(bus.w_col);
        xi = int'(bus.x_idx);
        if (bus.w_sel) begin
            bus.w_data <= w1_mem[r][c];
        end else if (r < IN0) begin
            bus.w_data <= w0_mem[r][c];
        end else begin
            bus.w_data <= '0;
        end
        if (xi < IN0) begin
            bus.x_data <= x_mem[xi];
        end else begin
            bus.x_data <= '0;
        end
    end

    // Address trace while busy, with repeats of a held address collapsed.
    always @(negedge clk) begin : addr_trace
        int t;
        if (bus.busy === 1'b1) begin
            t = int'(bus.w_sel) * 1000 + int'(bus.w_row) * 100 + int'(bus.w_col) * 10 + int'(bus.x_idx);
            if (addr_log.size() == 0 || addr_log[$] != t) begin
                addr_log.push_back(t);
            end
        end
    end

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) begin
            return 32767;
        end
        if (v < -32768) begin
            return -32768;
        end
        return v;
    endfunction

    // Reference: the two matrix-vector products straight from their definition.
    task automatic compute_model();
        longint acc;
        for (int c = 0; c < H; c++) begin
            acc = 0;
            for (int r = 0; r < IN0; r++) begin
                acc += longint'(x_mem[r]) * longint'(w0_mem[r][c]);
            end
            exp_h0[c] = sat16(acc >>> FRAC);
        end
        for (int c = 0; c < H; c++) begin
            acc = 0;
            for (int r = 0; r < H; r++) begin
                acc += exp_h0[r] * longint'(w1_mem[r][c]);
            end
            exp_h1[c] = sat16(acc >>> FRAC);
        end
    endtask

    task automatic load_ref();
        x_mem  = '{16'sd2, -16'sd3};
        w0_mem = '{'{16'sd2, -16'sd10, -16'sd10, 16'sd3},
                   '{16'sd6, 16'sd9, 16'sd12, 16'sd1}};
        w1_mem = '{'{-16'sd2, -16'sd3, -16'sd5, -16'sd3},
                   '{-16'sd1, 16'sd10, -16'sd2, -16'sd6},
                   '{16'sd4, 16'sd11, 16'sd3, -16'sd12},
                   '{-16'sd11, -16'sd4, 16'sd3, -16'sd1}};
    endtask

    function automatic logic signed [W-1:0] rand_val(input bit full);
        if (full) begin
            return W'($urandom);
        end
        return W'(int'($urandom_range(0, 40)) - 20);
    endfunction

    task automatic load_random(input bit full);
        for (int r = 0; r < IN0; r++) begin
            x_mem[r] = rand_val(full);
            for (int c = 0; c < H; c++) begin
                w0_mem[r][c] = rand_val(full);
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < H; c++) begin
                w1_mem[r][c] = rand_val(full);
            end
        end
    endtask

    task automatic fill_all(input logic signed [W-1:0] xv, input logic signed [W-1:0] wv);
        for (int r = 0; r < IN0; r++) begin
            x_mem[r] = xv;
            for (int c = 0; c < H; c++) begin
                w0_mem[r][c] = wv;
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < H; c++) begin
                w1_mem[r][c] = wv;
            end
        end
    endtask

    // Compare h1 (through the read port) and h0 against the expected vectors.
    task automatic check_results(input string tag);
        check({tag, "_h_valid"}, bus.h_valid, 1);
        for (int i = 0; i < H; i++) begin
            bus.h_idx = AW'(i);
            #1;
            check($sformatf("%s_h1[%0d]", tag, i), $signed(bus.h_data), exp_h1[i]);
            check($sformatf("%s_h0[%0d]", tag, i), $signed(dut.h0_q[i]), exp_h0[i]);
        end
    endtask

    // One start pulse, then a bounded observation window; optional second start and mid-run reset.
    task automatic run_once(input int again_at, input int rst_at,
                            output int first_done, output int n_done, output int n_busy);
        first_done = 0;
        n_done     = 0;
        n_busy     = 0;
        @(negedge clk);
        addr_log.delete();
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= RUN_LIMIT; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst_n     = 1'b1;
            if (bus.busy === 1'b1) begin
                n_busy++;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = cyc;
                end
            end
            if (cyc == again_at) begin
                bus.start = 1'b1;
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
            end
        end
    endtask

    task automatic normal_run(input string tag, input int again_at);
        int fd, nd, nb;
        run_once(again_at, 0, fd, nd, nb);
        check({tag, "_done_cycle"}, fd, EXP_CYC);
        check({tag, "_done_count"}, nd, 1);
        check({tag, "_busy_cycles"}, nb, EXP_CYC);
        check_results(tag);
    endtask

    initial begin
        int fd, nd, nb;
        int exp_seq [$];
        int k;
        int done_cycles [$];
        longint first_h1 [H];

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.h_idx = '0;
        load_ref();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_h_valid", bus.h_valid, 0);
        check("rst_w_sel", bus.w_sel, 0);
        check("rst_w_row", bus.w_row, 0);
        check("rst_w_col", bus.w_col, 0);
        check("rst_x_idx", bus.x_idx, 0);
        for (int i = 0; i < H; i++) begin
            bus.h_idx = AW'(i);
            #1;
            check($sformatf("rst_h_data[%0d]", i), $signed(bus.h_data), 0);
        end

        // Reference vectors with hand-computed results
        load_ref();
        exp_h0 = '{-14, -47, -56, 3};
        exp_h1 = '{-182, -1056, 5, 993};
        normal_run("ref", 0);

        // Address order: layer by layer, column by column, row fastest
        for (int l = 0; l < 2; l++) begin
            k = (l == 0) ? IN0 : H;
            for (int c = 0; c < H; c++) begin
                for (int r = 0; r < k; r++) begin
                    exp_seq.push_back(l * 1000 + r * 100 + c * 10 + r);
                end
            end
        end
        check("addr_count", addr_log.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < addr_log.size(); i++) begin
            check($sformatf("addr_seq[%0d]", i), addr_log[i], exp_seq[i]);
        end

        // Positive and negative saturation
        fill_all(16'sd32767, 16'sd32767);
        compute_model();
        normal_run("sat_pos", 0);
        fill_all(-16'sd32768, 16'sd32767);
        compute_model();
        normal_run("sat_neg", 0);

        // Start while busy is ignored
        load_random(1'b0);
        compute_model();
        normal_run("start_busy", 10);

        // Reset mid-run
        load_random(1'b0);
        compute_model();
        run_once(0, 30, fd, nd, nb);
        check("midrst_done_count", nd, 0);
        check("midrst_busy_cycles", nb, 30);
        check("midrst_busy", bus.busy, 0);
        check("midrst_h_valid", bus.h_valid, 0);
        for (int i = 0; i < H; i++) begin
            bus.h_idx = AW'(i);
            #1;
            check($sformatf("midrst_h_data[%0d]", i), $signed(bus.h_data), 0);
        end
        normal_run("after_rst", 0);

        // Randomized runs, alternating small and full-range operands
        for (int t = 0; t < 4; t++) begin
            load_random(t[0]);
            compute_model();
            normal_run($sformatf("rand%0d", t), 0);
        end

        // Back-to-back runs with start held high across DONE
        load_ref();
        compute_model();
        first_h1 = exp_h1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 125; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cycles.push_back(cyc);
            end
            if (cyc == 58) begin
                check("b2b_gap_busy", bus.busy, 0);
                check("b2b_gap_h_valid", bus.h_valid, 1);
                for (int i = 0; i < H; i++) begin
                    bus.h_idx = AW'(i);
                    #1;
                    check($sformatf("b2b_first_h1[%0d]", i), $signed(bus.h_data), first_h1[i]);
                end
                x_mem = '{16'sd1, 16'sd0};
                for (int c = 0; c < H; c++) begin
                    w0_mem[0][c] = rand_val(1'b0);
                    w0_mem[1][c] = rand_val(1'b0);
                end
                compute_model();
            end
            if (cyc == 59) begin
                check("b2b_restart_busy", bus.busy, 1);
                check("b2b_restart_h_valid", bus.h_valid, 0);
            end
            if (cyc == 115) begin
                bus.start = 1'b0;
            end
        end
        check("b2b_done_count", done_cycles.size(), 2);
        if (done_cycles.size() == 2) begin
            check("b2b_done1_cycle", done_cycles[0], EXP_CYC);
            check("b2b_done2_cycle", done_cycles[1], 2 * EXP_CYC + 1);
        end
        check_results("b2b_second");
        for (int c = 0; c < H; c++) begin
            check($sformatf("b2b_h0_row0[%0d]", c), $signed(dut.h0_q[c]), longint'(w0_mem[0][c]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
